// File: rtl/alu_seq_pkg.sv
// Shared definitions for the alu_sequencer: opcodes, FSM states and ALU control codes.
package alu_seq_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_NOR = 4'h4;
    localparam logic [3:0] OP_SHL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_CLR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_JC  = 4'hA;
    localparam logic [3:0] OP_OUT = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        OPERAND,
        EXEC,
        WB,
        HALT
    } state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] shift;
    } alu_ctrl_t;

    localparam alu_ctrl_t ALU_ADD = '{sel: 2'b10, shift: 2'b01};
    localparam alu_ctrl_t ALU_SUB = '{sel: 2'b11, shift: 2'b00};
    localparam alu_ctrl_t ALU_NOR = '{sel: 2'b01, shift: 2'b00};
    localparam alu_ctrl_t ALU_SHL = '{sel: 2'b00, shift: 2'b01};
    localparam alu_ctrl_t ALU_SHR = '{sel: 2'b00, shift: 2'b11};
    localparam alu_ctrl_t ALU_CLR = '{sel: 2'b00, shift: 2'b00};
    // Idle code shares the CLR encoding; loadAlu low marks it as "no operation".
    localparam alu_ctrl_t ALU_PASS = '{sel: 2'b00, shift: 2'b00};

    function automatic logic is_two_byte_op(input logic [3:0] op);
        return op inside {OP_LDI, OP_ADD, OP_SUB, OP_NOR, OP_JMP, OP_JZ, OP_JC};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: ALU controls plus instruction class flags.
module instr_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output logic [1:0] alu_sel,
    output logic [1:0] shift_sel,
    output logic       is_alu,
    output logic       is_two_byte,
    output logic       is_branch,
    output logic       is_illegal
);

    alu_ctrl_t ctrl;

    always_comb begin
        ctrl       = ALU_PASS;
        is_alu     = 1'b0;
        is_branch  = 1'b0;
        is_illegal = 1'b0;
        case (opcode)
            OP_ADD: begin ctrl = ALU_ADD; is_alu = 1'b1; end
            OP_SUB: begin ctrl = ALU_SUB; is_alu = 1'b1; end
            OP_NOR: begin ctrl = ALU_NOR; is_alu = 1'b1; end
            OP_SHL: begin ctrl = ALU_SHL; is_alu = 1'b1; end
            OP_SHR: begin ctrl = ALU_SHR; is_alu = 1'b1; end
            OP_CLR: begin ctrl = ALU_CLR; is_alu = 1'b1; end
            OP_JMP, OP_JZ, OP_JC: is_branch = 1'b1;
            4'hC, 4'hD, 4'hE: is_illegal = 1'b1;
            default: ;
        endcase
    end

    assign alu_sel     = ctrl.sel;
    assign shift_sel   = ctrl.shift;
    assign is_two_byte = is_two_byte_op(opcode);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute controller for the 8-bit datapath: owns pc, acc, operand,
// flags and the output port, and drives the external ALU.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int              PC_W   = 8,
    parameter logic [PC_W-1:0] RST_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic [PC_W-1:0] pmem_addr,
    input  logic [7:0]      pmem_data,
    output logic [7:0]      alu_a,
    output logic [7:0]      alu_b,
    output logic [1:0]      ALU_sel,
    output logic [1:0]      load_shift,
    output logic            loadAlu,
    input  logic [7:0]      alu_result,
    input  logic            alu_cout,
    input  logic            alu_zout,
    output logic [7:0]      out_data,
    output logic            out_valid,
    output logic            halted,
    output logic            illegal
);

    state_t          state, state_next;
    logic [PC_W-1:0] pc;
    logic [7:0]      acc, opnd, ir;
    logic            c_flag, z_flag;

    logic [3:0] dec_opcode;
    logic [1:0] dec_sel, dec_shift;
    logic       dec_alu, dec_two_byte, dec_branch, dec_illegal;
    logic       branch_taken;
    logic       unused_ir_low;

    // In DECODE the opcode is still on the memory bus; afterwards it lives in ir.
    assign dec_opcode = (state == DECODE) ? pmem_data[7:4] : ir[7:4];

    instr_decode u_decode (
        .opcode      (dec_opcode),
        .alu_sel     (dec_sel),
        .shift_sel   (dec_shift),
        .is_alu      (dec_alu),
        .is_two_byte (dec_two_byte),
        .is_branch   (dec_branch),
        .is_illegal  (dec_illegal)
    );

    assign branch_taken = dec_branch &&
                          ((dec_opcode == OP_JMP) ||
                           ((dec_opcode == OP_JZ) && z_flag) ||
                           ((dec_opcode == OP_JC) && c_flag));

    assign pmem_addr     = pc;
    assign alu_a         = acc;
    assign alu_b         = opnd;
    assign halted        = (state == HALT);
    assign unused_ir_low = ^ir[3:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        ALU_sel    = 2'b00;
        load_shift = 2'b00;
        loadAlu    = 1'b0;
        case (state)
            FETCH:   if (run) state_next = DECODE;
            DECODE:  state_next = dec_two_byte ? OPERAND : EXEC;
            OPERAND: state_next = EXEC;
            EXEC: begin
                if (dec_alu)                   state_next = WB;
                else if (dec_opcode == OP_HLT) state_next = HALT;
                else                           state_next = FETCH;
            end
            WB:      state_next = FETCH;
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
        // ALU controls are held identical through EXEC and WB so the result is stable.
        if (((state == EXEC) || (state == WB)) && dec_alu) begin
            ALU_sel    = dec_sel;
            load_shift = dec_shift;
            loadAlu    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RST_PC;
            acc       <= '0;
            opnd      <= '0;
            ir        <= '0;
            c_flag    <= 1'b0;
            z_flag    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                FETCH: if (run) pc <= pc + PC_W'(1);
                DECODE: begin
                    ir <= pmem_data;
                    if (dec_two_byte) pc <= pc + PC_W'(1);
                end
                OPERAND: opnd <= pmem_data;
                EXEC: begin
                    if (dec_illegal)           illegal <= 1'b1;
                    if (branch_taken)          pc      <= PC_W'(opnd);
                    if (dec_opcode == OP_LDI)  acc     <= opnd;
                    if (dec_opcode == OP_OUT) begin
                        out_data  <= acc;
                        out_valid <= 1'b1;
                    end
                end
                WB: begin
                    acc    <= alu_result;
                    c_flag <= alu_cout;
                    z_flag <= alu_zout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a ROM model, an ALU model and an output scoreboard.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic [7:0] pmem_addr, pmem_data;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [1:0] ALU_sel, load_shift;
    logic       loadAlu, alu_cout, alu_zout;
    logic [7:0] out_data;
    logic       out_valid, halted, illegal;

    logic [7:0] rom [256];
    logic [7:0] prog [$];
    logic [7:0] expq [$];
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         cycles;

    alu_sequencer #(.PC_W(8), .RST_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .pmem_addr  (pmem_addr),
        .pmem_data  (pmem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .ALU_sel    (ALU_sel),
        .load_shift (load_shift),
        .loadAlu    (loadAlu),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .alu_zout   (alu_zout),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pmem_data <= rom[pmem_addr];

    // Reference ALU: cout is carry for ADD, no-borrow for SUB, shifted-out bit for shifts.
    always_comb begin
        alu_result = 8'h00;
        alu_cout   = 1'b0;
        case ({ALU_sel, load_shift})
            4'b1001: {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'b1100: begin alu_result = alu_a - alu_b; alu_cout = (alu_a >= alu_b); end
            4'b0100: alu_result = ~(alu_a | alu_b);
            4'b0001: begin alu_result = {alu_a[6:0], 1'b0}; alu_cout = alu_a[7]; end
            4'b0011: begin alu_result = {1'b0, alu_a[7:1]}; alu_cout = alu_a[0]; end
            default: ;
        endcase
        alu_zout = (alu_result == 8'h00);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            pulses++;
            if (expq.size() == 0) checkOutput("out_unexpected", {31'd0, out_valid}, 32'd0);
            else                  checkOutput("out_data", {24'd0, out_data}, {24'd0, expq.pop_front()});
        end
    end

    task automatic clearRom();
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
    endtask

    task automatic placeProg(input logic [7:0] base);
        logic [7:0] a;
        for (int i = 0; i < prog.size(); i++) begin
            a = base + 8'(i);
            rom[a] = prog[i];
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        expq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
    endtask

    // Runs until HALT or the cycle budget expires; counts rising edges from run=1.
    task automatic applyStimulus(input int max_cycles, output int n);
        n = 0;
        run = 1'b1;
        while (!halted && n < max_cycles) begin
            @(posedge clk);
            n++;
            #1;
        end
        run = 1'b0;
        checkOutput("halt_reached", {31'd0, halted}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        run = 1'b0;
        clearRom();

        // LDI 5, ADD 3, OUT, HLT
        prog = {8'h10, 8'h05, 8'h20, 8'h03, 8'hB0, 8'hF0};
        placeProg(8'h00);
        resetDut();
        checkOutput("reset_pc", {24'd0, pmem_addr}, 32'h00);
        checkOutput("reset_acc", {24'd0, alu_a}, 32'h00);
        checkOutput("reset_opnd", {24'd0, alu_b}, 32'h00);
        checkOutput("reset_alu_ctrl", {27'd0, ALU_sel, load_shift, loadAlu}, 32'h0);
        checkOutput("reset_out", {22'd0, out_data, out_valid, halted}, 32'h0);
        checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
        expq.push_back(8'h08);
        applyStimulus(40, cycles);
        checkOutput("t1_cycles", cycles, 32'd15);
        checkOutput("t1_pulses", pulses, 32'd1);
        checkOutput("t1_queue_empty", expq.size(), 32'd0);
        checkOutput("t1_illegal", {31'd0, illegal}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t1_halt_pc", {24'd0, pmem_addr}, 32'h06);
        checkOutput("t1_halt_hold", {31'd0, halted}, 32'd1);

        // SUB to zero sets Z and C; JZ then JC both taken
        clearRom();
        prog = {8'h10, 8'h05, 8'h30, 8'h05, 8'h90, 8'h0A};
        placeProg(8'h00);
        prog = {8'hA0, 8'h0E, 8'hF0, 8'hF0, 8'hB0, 8'hF0};
        placeProg(8'h0A);
        resetDut();
        expq.push_back(8'h00);
        applyStimulus(60, cycles);
        checkOutput("t2_pc", {24'd0, pmem_addr}, 32'h10);
        checkOutput("t2_acc", {24'd0, alu_a}, 32'h00);
        checkOutput("t2_queue_empty", expq.size(), 32'd0);

        // SHL of 0x80 gives zero with carry out; JC follows it
        clearRom();
        prog = {8'h10, 8'h80, 8'h50, 8'hA0, 8'h20, 8'h10, 8'h11, 8'hB0, 8'hF0};
        placeProg(8'h00);
        prog = {8'hB0, 8'hF0};
        placeProg(8'h20);
        resetDut();
        expq.push_back(8'h00);
        applyStimulus(60, cycles);
        checkOutput("t3_pc", {24'd0, pmem_addr}, 32'h22);
        checkOutput("t3_acc", {24'd0, alu_a}, 32'h00);
        checkOutput("t3_queue_empty", expq.size(), 32'd0);

        // Illegal opcode: sticky flag, acc untouched, one-byte advance
        clearRom();
        prog = {8'h10, 8'h33, 8'hC0, 8'hB0, 8'hF0};
        placeProg(8'h00);
        resetDut();
        expq.push_back(8'h33);
        run = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("t4_pre_illegal", {31'd0, illegal}, 32'd0);
        checkOutput("t4_pre_pc", {24'd0, pmem_addr}, 32'h02);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t4_illegal_set", {31'd0, illegal}, 32'd1);
        checkOutput("t4_pc_plus1", {24'd0, pmem_addr}, 32'h03);
        checkOutput("t4_acc_kept", {24'd0, alu_a}, 32'h33);
        applyStimulus(30, cycles);
        checkOutput("t4_cycles", cycles, 32'd6);
        checkOutput("t4_illegal_sticky", {31'd0, illegal}, 32'd1);
        checkOutput("t4_queue_empty", expq.size(), 32'd0);

        // ADD carry, NOR, SHR, CLR, untaken JC, taken JZ
        clearRom();
        prog = {8'h10, 8'hF0, 8'h20, 8'h20, 8'hA0, 8'h08, 8'hF0, 8'hF0,
                8'hB0, 8'h40, 8'h0F, 8'hB0, 8'h60, 8'hB0, 8'hA0, 8'h12,
                8'h70, 8'h90, 8'h15, 8'hF0, 8'hF0, 8'hB0, 8'hF0};
        placeProg(8'h00);
        resetDut();
        expq.push_back(8'h10);
        expq.push_back(8'hE0);
        expq.push_back(8'h70);
        expq.push_back(8'h00);
        applyStimulus(200, cycles);
        checkOutput("t5_pc", {24'd0, pmem_addr}, 32'h17);
        checkOutput("t5_pulses", pulses, 32'd4);
        checkOutput("t5_queue_empty", expq.size(), 32'd0);

        // run=0 stalls in FETCH; reset mid-OPERAND aborts the instruction
        clearRom();
        prog = {8'h10, 8'h05, 8'h20, 8'h03, 8'hB0, 8'hF0};
        placeProg(8'h00);
        resetDut();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("t6_stall0", {23'd0, pmem_addr, loadAlu}, 32'h000);
        end
        run = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("t6_stall2", {15'd0, pmem_addr, alu_a, loadAlu}, {15'd0, 8'h02, 8'h05, 1'b0});
        end
        run = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_pc", {24'd0, pmem_addr}, 32'h00);
        checkOutput("t6_rst_acc_opnd", {16'd0, alu_a, alu_b}, 32'h0);
        checkOutput("t6_rst_ctrl", {27'd0, ALU_sel, load_shift, loadAlu}, 32'h0);
        checkOutput("t6_rst_out", {21'd0, out_data, out_valid, halted, illegal}, 32'h0);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        expq.push_back(8'h08);
        applyStimulus(40, cycles);
        checkOutput("t6_restart_cycles", cycles, 32'd15);
        checkOutput("t6_queue_empty", expq.size(), 32'd0);

        // Two-byte instruction at 0xFF takes its operand from address 0
        clearRom();
        rom[8'h00] = 8'h7E;
        rom[8'h01] = 8'h80;
        rom[8'h02] = 8'hFF;
        rom[8'hFF] = 8'h10;
        resetDut();
        run = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        run = 1'b0;
        checkOutput("t7_acc", {24'd0, alu_a}, 32'h7E);
        checkOutput("t7_pc_wrap", {24'd0, pmem_addr}, 32'h01);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t7_pc_hold", {24'd0, pmem_addr}, 32'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
